// File: rtl/bc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bc_pkg : shared types and helpers for the BC-MAC bitstream blocks     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bc_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int unsigned sat_mag(input int unsigned v, input int unsigned len);
      return (v > 8 * len) ? 8 * len : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/therm_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | therm_8 : count (0..8) to 8-bit thermometer word, ones in low bits    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module therm_8
   import bc_pkg::*;
(
   input  logic [3:0]        cnt,
   output logic [LANE_W-1:0] word
);

   always_comb begin
      word = '0;
      for (int i = 0; i < LANE_W; i++) begin
         word[i] = (32'(cnt) > i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/bitstream_gen_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitstream_gen_8 : expands a magnitude into LEN thermometer words      |
// | whose total popcount equals the (saturated) magnitude. Rev 1.0        |
// +----------------------------------------------------------------------+
module bitstream_gen_8
   import bc_pkg::*;
#(
   parameter int LEN = 16,
   parameter int W   = $clog2(8 * LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_word,
   output logic              out_last
);

   localparam int C_LG = $clog2(LEN);
   localparam int C_AW = W + C_LG;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [W-1:0]        r_vs;
   logic [C_AW-1:0]     r_acc;
   logic [C_LG-1:0]     r_k;
   logic [LANE_W-1:0]   r_word;
   logic                r_last;

   logic [W-1:0]        w_vs_in;
   logic [W-1:0]        w_vs_sel;
   logic [C_AW-1:0]     w_acc_lo;
   logic [C_AW-1:0]     w_acc_hi;
   logic [3:0]          w_n;
   logic [LANE_W-1:0]   w_word_nxt;
   logic                w_accept;
   logic                w_beat;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_beat   = (r_state == RUN) && out_ready;

   assign w_vs_in  = W'(sat_mag(32'(in_value), 32'(LEN)));
   assign w_vs_sel = (r_state == IDLE) ? w_vs_in : r_vs;

   // The word being registered is word k+1 in RUN (acc already covers k words) or word 0 on accept.
   assign w_acc_lo = (r_state == IDLE) ? '0 : r_acc + C_AW'(r_vs);
   assign w_acc_hi = w_acc_lo + C_AW'(w_vs_sel);
   assign w_n      = 4'((w_acc_hi >> C_LG) - (w_acc_lo >> C_LG));

   therm_8 u_therm (
      .cnt  (w_n),
      .word (w_word_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = RUN;
         RUN:     if (out_ready && r_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs   <= '0;
         r_acc  <= '0;
         r_k    <= '0;
         r_word <= '0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_vs   <= w_vs_in;
         r_acc  <= '0;
         r_k    <= '0;
         r_word <= w_word_nxt;
         r_last <= 1'b0;
      end else if (w_beat) begin
         if (r_last) begin
            r_acc  <= '0;
            r_k    <= '0;
            r_word <= '0;
            r_last <= 1'b0;
         end else begin
            r_acc  <= w_acc_lo;
            r_k    <= r_k + C_LG'(1);
            r_word <= w_word_nxt;
            r_last <= ((r_k + C_LG'(1)) == C_LG'(LEN - 1));
         end
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == RUN);
   assign out_word  = r_word;
   assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_gen_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bitstream_gen_8 : randomized self-checking bench with a division-  |
// | based stream model and per-cycle output comparison. Rev 1.0           |
// +----------------------------------------------------------------------+
module tb_bitstream_gen_8;

   localparam int LEN = 16;
   localparam int W   = $clog2(8 * LEN + 1);

   typedef struct {
      logic [7:0] word;
      logic       last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_value;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_word;
   logic          out_last;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];
   int   vs_q[$];
   int   popsum     = 0;
   int   beats_done = 0;
   int   rdy_mode   = 0;
   int   stall_cnt  = 0;

   bitstream_gen_8 #(.LEN(LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: word k carries floor((k+1)*Vs/LEN) - floor(k*Vs/LEN) ones.
   function automatic logic [7:0] model_word(input int v, input int k);
      int vs;
      int n;
      vs = (v > 8 * LEN) ? 8 * LEN : v;
      n  = ((k + 1) * vs) / LEN - (k * vs) / LEN;
      return 8'((1 << n) - 1);
   endfunction

   task automatic push_stream(input int v);
      exp_t e;
      for (int k = 0; k < LEN; k++) begin
         e.word = model_word(v, k);
         e.last = (k == LEN - 1);
         exp_q.push_back(e);
      end
      vs_q.push_back((v > 8 * LEN) ? 8 * LEN : v);
   endtask

   task automatic accept(input int v);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("in_ready_wait", in_ready, 1);
      in_valid  = 1'b1;
      in_value  = W'(v);
      stall_cnt = 0;
      push_stream(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_value = W'($urandom);
      chk("first_word_latency", out_valid, 1);
   endtask

   task automatic send(input int v, input bit check_rate);
      int t;
      accept(v);
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("stream_drained", exp_q.size(), 0);
      if (check_rate) chk("stream_cycles", t, LEN);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
   endtask

   // Output comparison against the queued model stream on every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("ready_vs_valid", in_ready, !out_valid);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", out_valid, 0);
               end else begin
                  chk("word", out_word, exp_q[0].word);
                  chk("last", out_last, exp_q[0].last);
                  if (out_ready) begin
                     popsum += $countones(out_word);
                     beats_done++;
                     if (exp_q[0].last) begin
                        chk("popsum", popsum, vs_q.pop_front());
                        popsum     = 0;
                        beats_done = 0;
                     end
                     void'(exp_q.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (beats_done == 5 && stall_cnt < 3) begin
                  out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      int t;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_word", out_word, 8'h00);
      chk("rst_out_last", out_last, 0);

      chk("model_v24_k0", model_word(24, 0), 8'h01);
      chk("model_v24_k1", model_word(24, 1), 8'h03);
      chk("model_v128_k3", model_word(128, 3), 8'hFF);
      chk("model_v200_k9", model_word(200, 9), 8'hFF);
      chk("model_v100_k0", model_word(100, 0), 8'h3F);
      chk("model_v0_k5", model_word(0, 5), 8'h00);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      rdy_mode = 0;
      send(0, 1);
      send(128, 1);
      send(24, 1);
      send(200, 1);

      rdy_mode = 2;
      send(24, 0);
      chk("stall_applied", stall_cnt, 3);

      rdy_mode = 0;
      accept(100);
      t = 0;
      while (beats_done < 7 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("reach_beat7", beats_done, 7);
      #2;
      rst = 1'b1;
      exp_q.delete();
      vs_q.delete();
      popsum     = 0;
      beats_done = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_last", out_last, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send(16, 1);

      rdy_mode = 1;
      for (int i = 0; i < 30; i++) begin
         send(int'($urandom_range(0, 255)), 0);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end
      rdy_mode = 0;
      send(255, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
